// File: rtl/rsp_reorder_buf_pkg.sv
// ============================================================================
// Module  : rsp_reorder_buf_pkg
// Brief   : Shared widths and packet types for the execution-unit response path.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package rsp_reorder_buf_pkg;

    localparam int ID_W    = 3;
    localparam int DATA_W  = 64;
    localparam int NUM_IDS = 2**ID_W;

    typedef logic [ID_W-1:0] id_t;

    typedef struct packed {
        logic              rsp;
        id_t               rsp_id;
        logic [DATA_W-1:0] rsp_data;
    } rsp_pkt_type;

endpackage

`default_nettype wire

// File: rtl/rsp_reorder_buf_if.sv
// ============================================================================
// Module  : rsp_reorder_buf_if
// Brief   : In-order response stream (valid/ready) leaving the reorder buffer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface rsp_reorder_buf_if;
    import rsp_reorder_buf_pkg::*;

    logic              out_vld;
    id_t               out_id;
    logic [DATA_W-1:0] out_data;
    logic              out_rdy;

    modport master (
        output out_vld,
        output out_id,
        output out_data,
        input  out_rdy
    );

    modport slave (
        input  out_vld,
        input  out_id,
        input  out_data,
        output out_rdy
    );

endinterface

`default_nettype wire

// File: rtl/rob_order_fifo.sv
// ============================================================================
// Module  : rob_order_fifo
// Brief   : NUM_IDS x ID_W circular FIFO holding request IDs in issue order.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rob_order_fifo #(
    parameter int ID_W    = 3,
    parameter int NUM_IDS = 2**ID_W
) (
    input  logic            clk,
    input  logic            rst_b,
    input  logic            push,
    input  logic [ID_W-1:0] push_id,
    input  logic            pop,
    output logic [ID_W-1:0] head_id,
    output logic [ID_W:0]   count,
    output logic            full,
    output logic            empty
);

    localparam logic [ID_W:0] c_ptr_one  = 1;
    localparam logic [ID_W:0] c_full_cnt = NUM_IDS;

    logic [ID_W-1:0] r_mem [NUM_IDS];
    logic [ID_W:0]   r_wr_ptr;
    logic [ID_W:0]   r_rd_ptr;

    // Pointers carry one extra bit so a full queue is distinguishable from empty.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
            if (pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
        end
    end

    always_ff @(posedge clk) begin
        if (push) r_mem[r_wr_ptr[ID_W-1:0]] <= push_id;
    end

    assign head_id = r_mem[r_rd_ptr[ID_W-1:0]];
    assign count   = r_wr_ptr - r_rd_ptr;
    assign full    = (count == c_full_cnt);
    assign empty   = (count == '0);

endmodule

`default_nettype wire

// File: rtl/rsp_reorder_buf.sv
// ============================================================================
// Module  : rsp_reorder_buf
// Brief   : Holds out-of-order execution-unit responses and releases them in issue order.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rsp_reorder_buf
    import rsp_reorder_buf_pkg::*;
#(
    parameter int ID_W    = rsp_reorder_buf_pkg::ID_W,
    parameter int DATA_W  = rsp_reorder_buf_pkg::DATA_W,
    parameter int NUM_IDS = 2**ID_W
) (
    input  logic                 clk,
    input  logic                 rst_b,
    input  logic                 issue_vld,
    input  logic [ID_W-1:0]      issue_id,
    input  rsp_pkt_type          rsp_in,
    rsp_reorder_buf_if.master    out_if,
    output logic [NUM_IDS-1:0]   id_busy,
    output logic                 order_full,
    output logic                 err_dup_issue,
    output logic                 err_unexp_rsp
);

    localparam logic [ID_W:0] c_full_cnt = NUM_IDS;

    logic [NUM_IDS-1:0] r_busy;
    logic [NUM_IDS-1:0] r_done;
    logic [NUM_IDS-1:0] w_busy_nxt;
    logic [NUM_IDS-1:0] w_done_nxt;
    logic [DATA_W-1:0]  r_data [NUM_IDS];
    logic               r_err_dup;
    logic               r_err_unexp;

    logic [ID_W-1:0]    w_head_id;
    logic [ID_W-1:0]    w_rsp_id;
    logic [ID_W:0]      w_count;
    logic               w_full;
    logic               w_empty;
    logic               w_out_vld;
    logic               w_pop;
    logic               w_pop_this_id;
    logic               w_dup;
    logic               w_issue_acc;
    logic               w_push;
    logic               w_capture;
    logic               w_unexp;

    rob_order_fifo #(
        .ID_W    (ID_W),
        .NUM_IDS (NUM_IDS)
    ) u_order_fifo (
        .clk     (clk),
        .rst_b   (rst_b),
        .push    (w_push),
        .push_id (issue_id),
        .pop     (w_pop),
        .head_id (w_head_id),
        .count   (w_count),
        .full    (w_full),
        .empty   (w_empty)
    );

    assign w_rsp_id      = rsp_in.rsp_id;
    assign w_out_vld     = !w_empty && r_done[w_head_id];
    assign w_pop         = w_out_vld && out_if.out_rdy;
    assign w_pop_this_id = w_pop && (w_head_id == issue_id);

    // An ID being popped this cycle is free to be re-issued in the same cycle.
    assign w_dup       = issue_vld && r_busy[issue_id] && !w_pop_this_id;
    assign w_issue_acc = issue_vld && !w_dup;
    assign w_push      = w_issue_acc && (!w_full || w_pop);

    // Responses are qualified against pre-edge state only.
    assign w_capture = rsp_in.rsp && r_busy[w_rsp_id] && !r_done[w_rsp_id];
    assign w_unexp   = rsp_in.rsp && !w_capture;

    // Pop clear is applied first so a same-cycle re-issue of the head ID wins.
    always_comb begin
        w_busy_nxt = r_busy;
        w_done_nxt = r_done;
        if (w_pop) begin
            w_busy_nxt[w_head_id] = 1'b0;
            w_done_nxt[w_head_id] = 1'b0;
        end
        if (w_capture) begin
            w_done_nxt[w_rsp_id] = 1'b1;
        end
        if (w_issue_acc) begin
            w_busy_nxt[issue_id] = 1'b1;
            w_done_nxt[issue_id] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            r_busy      <= '0;
            r_done      <= '0;
            r_err_dup   <= 1'b0;
            r_err_unexp <= 1'b0;
        end else begin
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_err_dup   <= r_err_dup   | w_dup;
            r_err_unexp <= r_err_unexp | w_unexp;
        end
    end

    always_ff @(posedge clk) begin
        if (w_capture) r_data[w_rsp_id] <= rsp_in.rsp_data;
    end

    assign out_if.out_vld  = w_out_vld;
    assign out_if.out_id   = w_head_id;
    assign out_if.out_data = r_data[w_head_id];

    assign id_busy       = r_busy;
    assign order_full    = (w_count == c_full_cnt);
    assign err_dup_issue = r_err_dup;
    assign err_unexp_rsp = r_err_unexp;

endmodule

`default_nettype wire

// File: tb/tb_rsp_reorder_buf.sv
// ============================================================================
// Module  : tb_rsp_reorder_buf
// Brief   : Self-checking bench: issue-order scoreboard plus directed boundary checks.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rsp_reorder_buf;
    import rsp_reorder_buf_pkg::*;

    logic        clk;
    logic        rst_b;
    logic        issue_vld;
    id_t         issue_id;
    rsp_pkt_type rsp_in;
    logic [7:0]  id_busy;
    logic        order_full;
    logic        err_dup_issue;
    logic        err_unexp_rsp;

    int n_checks;
    int n_errors;

    rsp_reorder_buf_if rob_if ();

    rsp_reorder_buf u_dut (
        .clk           (clk),
        .rst_b         (rst_b),
        .issue_vld     (issue_vld),
        .issue_id      (issue_id),
        .rsp_in        (rsp_in),
        .out_if        (rob_if),
        .id_busy       (id_busy),
        .order_full    (order_full),
        .err_dup_issue (err_dup_issue),
        .err_unexp_rsp (err_unexp_rsp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: issue order queue plus per-ID response state, updated from
    // the stimulus seen just before each rising edge.
    id_t         m_q[$];
    logic [7:0]  m_busy;
    logic [7:0]  m_done;
    logic [63:0] m_data [8];
    logic        m_err_dup;
    logic        m_err_unexp;

    initial begin
        m_busy      = '0;
        m_done      = '0;
        m_err_dup   = 1'b0;
        m_err_unexp = 1'b0;
    end

    always @(negedge clk) begin : p_model
        logic exp_vld;
        logic m_pop;
        logic dup;
        logic cap;
        id_t  head;
        id_t  rid;
        if (!rst_b) begin
            m_q.delete();
            m_busy      = '0;
            m_done      = '0;
            m_err_dup   = 1'b0;
            m_err_unexp = 1'b0;
        end else begin
            head    = (m_q.size() != 0) ? m_q[0] : id_t'(0);
            exp_vld = (m_q.size() != 0) && m_done[head];
            chk("sb_out_vld", rob_if.out_vld, exp_vld);
            if (exp_vld) begin
                chk("sb_out_id", rob_if.out_id, head);
                chk("sb_out_data", rob_if.out_data, m_data[head]);
            end
            chk("sb_id_busy", id_busy, m_busy);
            chk("sb_order_full", order_full, m_q.size() == 8);
            chk("sb_err_dup", err_dup_issue, m_err_dup);
            chk("sb_err_unexp", err_unexp_rsp, m_err_unexp);

            m_pop = exp_vld && rob_if.out_rdy;
            dup   = issue_vld && m_busy[issue_id] && !(m_pop && head == issue_id);
            rid   = rsp_in.rsp_id;
            cap   = rsp_in.rsp && m_busy[rid] && !m_done[rid];
            if (dup) m_err_dup = 1'b1;
            if (rsp_in.rsp && !cap) m_err_unexp = 1'b1;
            if (m_pop) begin
                void'(m_q.pop_front());
                m_busy[head] = 1'b0;
                m_done[head] = 1'b0;
            end
            if (cap) begin
                m_data[rid] = rsp_in.rsp_data;
                m_done[rid] = 1'b1;
            end
            if (issue_vld && !dup) begin
                m_q.push_back(issue_id);
                m_busy[issue_id] = 1'b1;
                m_done[issue_id] = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_issue(input int id);
        issue_vld = 1'b1;
        issue_id  = id_t'(id);
        step();
        issue_vld = 1'b0;
    endtask

    task automatic do_rsp(input int id, input logic [63:0] d);
        rsp_in.rsp      = 1'b1;
        rsp_in.rsp_id   = id_t'(id);
        rsp_in.rsp_data = d;
        step();
        rsp_in.rsp = 1'b0;
    endtask

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        rst_b          = 1'b0;
        issue_vld      = 1'b0;
        issue_id       = '0;
        rsp_in         = '0;
        rob_if.out_rdy = 1'b1;
        repeat (2) step();
        rst_b = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_out_vld", rob_if.out_vld, 1'b0);
        chk("rst_id_busy", id_busy, 8'h00);
        chk("rst_order_full", order_full, 1'b0);
        chk("rst_err_dup", err_dup_issue, 1'b0);
        chk("rst_err_unexp", err_unexp_rsp, 1'b0);
        step();

        // In-order
        do_issue(0); do_issue(1); do_issue(2);
        do_rsp(0, 64'h10);
        @(negedge clk);
        chk("inord_first_id", rob_if.out_id, 0);
        chk("inord_first_data", rob_if.out_data, 64'h10);
        step();
        do_rsp(1, 64'h20); do_rsp(2, 64'h30);
        repeat (3) step();

        // Out-of-order
        do_issue(3); do_issue(5); do_issue(1);
        do_rsp(1, 64'hAA);
        do_rsp(5, 64'hBB);
        @(negedge clk);
        chk("ooo_wait_vld", rob_if.out_vld, 1'b0);
        step();
        do_rsp(3, 64'hCC);
        @(negedge clk);
        chk("ooo_head_id", rob_if.out_id, 3);
        chk("ooo_head_data", rob_if.out_data, 64'hCC);
        repeat (4) step();

        // Backpressure
        rob_if.out_rdy = 1'b0;
        do_issue(4);
        do_rsp(4, 64'h44);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_out_vld", rob_if.out_vld, 1'b1);
            chk("bp_out_id", rob_if.out_id, 4);
            chk("bp_out_data", rob_if.out_data, 64'h44);
            chk("bp_id_busy", id_busy, 8'h10);
        end
        step();
        rob_if.out_rdy = 1'b1;
        repeat (2) step();

        // Full plus duplicate
        rob_if.out_rdy = 1'b0;
        for (int i = 0; i < 8; i++) do_issue(i);
        @(negedge clk);
        chk("full_order_full", order_full, 1'b1);
        chk("full_id_busy", id_busy, 8'hFF);
        step();
        do_issue(4);
        @(negedge clk);
        chk("dup_err", err_dup_issue, 1'b1);
        chk("dup_order_full", order_full, 1'b1);
        chk("dup_id_busy", id_busy, 8'hFF);
        step();
        rob_if.out_rdy = 1'b1;
        for (int i = 0; i < 8; i++) do_rsp(i, 64'h100 + 64'(i));
        repeat (3) step();

        // Unexpected response, then pop/re-issue of the head ID
        do_rsp(6, 64'hDEAD);
        @(negedge clk);
        chk("unexp_err", err_unexp_rsp, 1'b1);
        step();
        rob_if.out_rdy = 1'b0;
        do_issue(2); do_issue(7);
        do_rsp(2, 64'h22);
        rob_if.out_rdy = 1'b1;
        do_issue(2);
        rob_if.out_rdy = 1'b0;
        @(negedge clk);
        chk("reissue_id_busy", id_busy, 8'h84);
        chk("reissue_out_vld", rob_if.out_vld, 1'b0);
        step();
        rob_if.out_rdy = 1'b1;
        do_rsp(7, 64'h77);
        do_rsp(2, 64'h2222);
        @(negedge clk);
        chk("reissue_tail_id", rob_if.out_id, 2);
        chk("reissue_tail_data", rob_if.out_data, 64'h2222);
        repeat (3) step();

        // Reset mid-operation
        rob_if.out_rdy = 1'b0;
        do_issue(1); do_issue(3); do_issue(5);
        do_rsp(3, 64'h33);
        rst_b = 1'b0;
        step();
        rst_b = 1'b1;
        @(negedge clk);
        chk("mrst_out_vld", rob_if.out_vld, 1'b0);
        chk("mrst_id_busy", id_busy, 8'h00);
        chk("mrst_err_dup", err_dup_issue, 1'b0);
        chk("mrst_err_unexp", err_unexp_rsp, 1'b0);
        chk("mrst_order_full", order_full, 1'b0);
        step();
        rob_if.out_rdy = 1'b1;
        do_issue(0);
        do_rsp(0, 64'h7777);
        @(negedge clk);
        chk("post_rst_vld", rob_if.out_vld, 1'b1);
        chk("post_rst_id", rob_if.out_id, 0);
        chk("post_rst_data", rob_if.out_data, 64'h7777);
        repeat (3) step();
        @(negedge clk);
        chk("end_id_busy", id_busy, 8'h00);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
